// File: rtl/a2d_pkg.sv
// Shared types, widths and the SPI command encoding for the A2D conversion sequencer.
package a2d_pkg;

    localparam int unsigned RES_W  = 12;
    localparam int unsigned CMD_W  = 16;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned NSLOT  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        GAP   = 2'd2,
        WAIT2 = 2'd3
    } state_t;

    typedef logic [1:0] slot_t;

    // ADC128S control word: channel select sits in bits [13:11], everything else zero
    typedef struct packed {
        logic [1:0]      rsvd;
        logic [CH_W-1:0] ch;
        logic [10:0]     pad;
    } cmd_t;

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [CH_W-1:0] ch);
        cmd_t c;
        c.rsvd = 2'b00;
        c.ch   = ch;
        c.pad  = 11'h000;
        return c;
    endfunction

endpackage

// File: rtl/a2d_sequencer_if.sv
// Handshake between the conversion sequencer and the SPI_mstr16 transaction engine.
interface a2d_sequencer_if;
    import a2d_pkg::*;

    logic             wrt;
    logic [CMD_W-1:0] cmd;
    logic             done;
    logic [CMD_W-1:0] rd_data;

    modport master (
        output wrt,
        output cmd,
        input  done,
        input  rd_data
    );

    modport slave (
        input  wrt,
        input  cmd,
        output done,
        output rd_data
    );

endinterface

// File: rtl/a2d_sequencer_tmo.sv
// Saturating wait counter; flags when LIMIT cycles have been spent in a wait state.
module a2d_sequencer_tmo #(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    assign expired_c = (cnt == CNT_W'(LIMIT));

    // Holds at LIMIT rather than wrapping so a missed abort can never look like a fresh wait
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/a2d_sequencer.sv
// Round-robin ADC128S conversion sequencer: two SPI frames per channel, four result registers.
module a2d_sequencer
    import a2d_pkg::*;
#(
    parameter logic [2:0]  CH_LFT   = 3'd0,
    parameter logic [2:0]  CH_RGHT  = 3'd4,
    parameter logic [2:0]  CH_STEER = 3'd5,
    parameter logic [2:0]  CH_BATT  = 3'd6,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nxt,
    a2d_sequencer_if.master   spi,
    output logic [RES_W-1:0]  lft_ld,
    output logic [RES_W-1:0]  rght_ld,
    output logic [RES_W-1:0]  steer_pot,
    output logic [RES_W-1:0]  batt,
    output logic              cnv_cmplt,
    output logic              busy,
    output logic              err
);

    state_t           state, state_n;
    slot_t            slot, slot_n;
    logic             wrt_q, wrt_n;
    logic [CMD_W-1:0] cmd_q, cmd_n;
    logic             cmplt_n, err_n, busy_n, cap_en;
    logic             tmo_clr, tmo_en, tmo_expired_c;
    logic [RES_W-1:0] res_q [NSLOT];
    logic             unused_rd_hi;

    // Upper nibble of the ADC frame carries no conversion data
    assign unused_rd_hi = ^spi.rd_data[CMD_W-1:RES_W];

    function automatic logic [CH_W-1:0] slot_ch(input slot_t s);
        logic [CH_W-1:0] ch;
        ch = CH_LFT;
        case (s)
            2'd0:    ch = CH_LFT;
            2'd1:    ch = CH_RGHT;
            2'd2:    ch = CH_STEER;
            2'd3:    ch = CH_BATT;
            default: ch = CH_LFT;
        endcase
        return ch;
    endfunction

    a2d_sequencer_tmo #(
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clr       (tmo_clr),
        .en        (tmo_en),
        .expired_c (tmo_expired_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= '0;
            wrt_q     <= 1'b0;
            cmd_q     <= '0;
            cnv_cmplt <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            slot      <= slot_n;
            wrt_q     <= wrt_n;
            cmd_q     <= cmd_n;
            cnv_cmplt <= cmplt_n;
            err       <= err_n;
            busy      <= busy_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                res_q[i] <= '0;
            end
        end else if (cap_en) begin
            res_q[slot] <= spi.rd_data[RES_W-1:0];
        end
    end

    // done is ignored while wrt is high: a stale level from the previous frame is still visible then
    always_comb begin
        state_n = state;
        slot_n  = slot;
        wrt_n   = 1'b0;
        cmd_n   = cmd_q;
        cmplt_n = 1'b0;
        err_n   = 1'b0;
        cap_en  = 1'b0;

        case (state)
            IDLE: begin
                if (nxt) begin
                    state_n = WAIT1;
                    wrt_n   = 1'b1;
                    cmd_n   = mk_cmd(slot_ch(slot));
                end
            end
            WAIT1: begin
                if (!wrt_q && spi.done) begin
                    state_n = GAP;
                end else if (tmo_expired_c) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            GAP: begin
                state_n = WAIT2;
                wrt_n   = 1'b1;
            end
            WAIT2: begin
                if (!wrt_q && spi.done) begin
                    state_n = IDLE;
                    cap_en  = 1'b1;
                    cmplt_n = 1'b1;
                    slot_n  = slot_t'(slot + slot_t'(1));
                end else if (tmo_expired_c) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n  = (state_n != IDLE);
        tmo_en  = (state == WAIT1) || (state == WAIT2);
        tmo_clr = (state_n != state);
    end

    assign spi.wrt   = wrt_q;
    assign spi.cmd   = cmd_q;
    assign lft_ld    = res_q[0];
    assign rght_ld   = res_q[1];
    assign steer_pot = res_q[2];
    assign batt      = res_q[3];

endmodule

// File: tb/tb_a2d_sequencer.sv
// Scoreboard bench for a2d_sequencer with an SPI_mstr16 responder stub and a slot/result reference model.
module tb_a2d_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        cnv_cmplt, busy, err;

    a2d_sequencer_if spi_if ();

    a2d_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .spi       (spi_if),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- SPI responder stub ----------------
    int unsigned resp_dly   = 40;
    bit          never_done = 1'b0;
    bit          hold_high  = 1'b0;
    logic [15:0] frame2_data = 16'h0000;
    int          conv_id    = 0;
    int          seen_id    = -1;
    int unsigned stub_cnt   = 0;
    bit          stub_f2    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            spi_if.done    <= 1'b0;
            spi_if.rd_data <= 16'h0000;
            stub_cnt       <= 0;
            seen_id        <= -1;
            stub_f2        <= 1'b0;
        end else if (spi_if.wrt) begin
            stub_f2 <= (seen_id == conv_id);
            seen_id <= conv_id;
            if (hold_high) begin
                spi_if.done    <= 1'b1;
                spi_if.rd_data <= (seen_id == conv_id) ? frame2_data : 16'($urandom);
                stub_cnt       <= 0;
            end else begin
                spi_if.done <= 1'b0;
                stub_cnt    <= never_done ? 0 : resp_dly;
            end
        end else if (stub_cnt == 1) begin
            spi_if.done    <= 1'b1;
            spi_if.rd_data <= stub_f2 ? frame2_data : 16'($urandom);
            stub_cnt       <= 0;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else if (hold_high) begin
            spi_if.done <= 1'b1;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [15:0] cmd;
        bit          second;
        int unsigned nxt_cyc;
    } wrt_exp_t;

    typedef struct packed {
        logic             is_err;
        logic [3:0][11:0] res;
    } end_exp_t;

    wrt_exp_t    wq[$];
    end_exp_t    dq[$];
    logic [3:0][11:0] m_res = '0;
    int unsigned m_slot = 0;
    int unsigned ch_tbl[4] = '{0, 4, 5, 6};

    task automatic start_conv(input logic [15:0] d, input bit tmo);
        wrt_exp_t w;
        end_exp_t e;
        conv_id++;
        frame2_data = d;
        never_done  = tmo;
        w.cmd     = 16'(ch_tbl[m_slot] * 2048);
        w.second  = 1'b0;
        w.nxt_cyc = cyc;
        wq.push_back(w);
        if (!tmo) begin
            w.second = 1'b1;
            wq.push_back(w);
            m_res[m_slot] = d[11:0];
            m_slot = (m_slot + 1) % 4;
        end
        e.is_err = tmo;
        e.res    = m_res;
        dq.push_back(e);
        nxt = 1'b1;
        @(posedge clk); #1;
        nxt = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || wq.size() != 0 || dq.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_reached", 64'(n < 3000), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_nxt();
        nxt = 1'b1;
        @(posedge clk); #1;
        nxt = 1'b0;
    endtask

    // ---------------- monitor ----------------
    int unsigned last_wrt_cyc = 0;
    int unsigned wrt_total = 0, cmplt_total = 0;

    always @(negedge clk) begin
        wrt_exp_t w;
        end_exp_t e;
        if (!rst) begin
            if (spi_if.wrt) begin
                wrt_total++;
                if (wq.size() == 0) begin
                    chk("unexpected_wrt", 64'd1, 64'd0);
                end else begin
                    w = wq.pop_front();
                    chk("cmd", 64'(spi_if.cmd), 64'(w.cmd));
                    chk("busy_at_wrt", 64'(busy), 64'd1);
                    if (w.second)
                        chk("frame_gap", 64'(cyc - last_wrt_cyc),
                            64'(hold_high ? 3 : resp_dly + 3));
                    else
                        chk("nxt_to_wrt", 64'(cyc - w.nxt_cyc), 64'd1);
                end
                last_wrt_cyc = cyc;
            end
            if (cnv_cmplt || err) begin
                if (cnv_cmplt) cmplt_total++;
                if (dq.size() == 0) begin
                    chk("unexpected_end", {62'd0, cnv_cmplt, err}, 64'd0);
                end else begin
                    e = dq.pop_front();
                    chk("end_kind", {62'd0, cnv_cmplt, err}, e.is_err ? 64'd1 : 64'd2);
                    chk("results", {16'd0, lft_ld, rght_ld, steer_pot, batt},
                        {16'd0, e.res[0], e.res[1], e.res[2], e.res[3]});
                    chk("busy_at_end", 64'(busy), 64'd0);
                    if (e.is_err)
                        chk("timeout_latency", 64'(cyc - last_wrt_cyc), 64'd1024);
                    else
                        chk("done_to_cmplt", 64'(cyc - last_wrt_cyc),
                            64'(hold_high ? 2 : resp_dly + 2));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int unsigned wbase, cbase, n;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_lft",   64'(lft_ld),     64'd0);
        chk("rst_rght",  64'(rght_ld),    64'd0);
        chk("rst_steer", 64'(steer_pot),  64'd0);
        chk("rst_batt",  64'(batt),       64'd0);
        chk("rst_wrt",   64'(spi_if.wrt), 64'd0);
        chk("rst_cmd",   64'(spi_if.cmd), 64'd0);
        chk("rst_busy",  64'(busy),       64'd0);
        chk("rst_flags", {62'd0, cnv_cmplt, err}, 64'd0);
        repeat (3) @(posedge clk); #1;

        // first conversion: upper nibble must be dropped
        start_conv(16'hF123, 1'b0);
        wait_idle();
        chk("lft_after_first", 64'(lft_ld), 64'h123);

        // walk back to slot 0, then one conversion per slot and a wrap
        for (int i = 0; i < 3; i++) begin
            start_conv(16'($urandom), 1'b0);
            wait_idle();
        end
        start_conv(16'h0ABC, 1'b0); wait_idle();
        start_conv(16'h0456, 1'b0); wait_idle();
        start_conv(16'h0789, 1'b0); wait_idle();
        start_conv(16'h0FFF, 1'b0); wait_idle();
        chk("four_slots", {16'd0, lft_ld, rght_ld, steer_pot, batt},
            {16'd0, 12'hABC, 12'h456, 12'h789, 12'hFFF});
        start_conv(16'h0321, 1'b0); wait_idle();

        // nxt while busy must be dropped
        wbase = wrt_total; cbase = cmplt_total;
        start_conv(16'h5A5A, 1'b0);
        repeat (5)  @(posedge clk); #1; pulse_nxt();
        repeat (25) @(posedge clk); #1; pulse_nxt();
        repeat (25) @(posedge clk); #1; pulse_nxt();
        wait_idle();
        chk("busy_nxt_wrts",   64'(wrt_total - wbase),   64'd2);
        chk("busy_nxt_cmplts", 64'(cmplt_total - cbase), 64'd1);

        // timeout abort, then retry of the same channel
        start_conv(16'h0BAD, 1'b1);
        wait_idle();
        never_done = 1'b0;
        start_conv(16'h0777, 1'b0);
        wait_idle();

        // synchronous reset in the middle of the second frame
        wbase = wrt_total;
        start_conv(16'h0E0E, 1'b0);
        n = 0;
        while (wrt_total < wbase + 2 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_wait2", 64'(n < 500), 64'd1);
        repeat (10) @(posedge clk); #1;
        rst = 1'b1;
        wq.delete();
        dq.delete();
        m_res  = '0;
        m_slot = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_results", {16'd0, lft_ld, rght_ld, steer_pot, batt}, 64'd0);
        chk("midrst_wrt",  64'(spi_if.wrt), 64'd0);
        chk("midrst_busy", 64'(busy),       64'd0);
        chk("midrst_cmd",  64'(spi_if.cmd), 64'd0);
        repeat (3) @(posedge clk); #1;
        start_conv(16'h0246, 1'b0);
        wait_idle();

        // done stuck high before the request
        hold_high = 1'b1;
        repeat (4) @(posedge clk); #1;
        start_conv(16'h0135, 1'b0);
        wait_idle();
        hold_high = 1'b0;
        repeat (2) @(posedge clk); #1;

        // randomized traffic
        for (int i = 0; i < 12; i++) begin
            resp_dly = $urandom_range(60, 1);
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
            start_conv(16'($urandom), 1'b0);
            wait_idle();
        end

        repeat (5) @(posedge clk); #1;
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
